// File: rtl/norm_shift_if.sv
// Request/result bundle for norm_shift_seq.
// The requester uses the master modport and the normalizer uses the slave modport.
interface norm_shift_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned STAGES = $clog2(WIDTH);

  logic              start;
  logic              dir;
  logic [WIDTH-1:0]  A;
  logic [WIDTH-1:0]  C;
  logic [STAGES:0]   count;
  logic              zero;
  logic              busy;
  logic              done;

  modport master (
    output start, dir, A,
    input  C, count, zero, busy, done
  );

  modport slave (
    input  start, dir, A,
    output C, count, zero, busy, done
  );
endinterface

// File: rtl/norm_shift_seq.sv
// Sequential normalizer built as a binary search with one power-of-two stage per cycle.
// dir=0 counts leading zeros and shifts left until the MSB is set.
// dir=1 counts trailing zeros and shifts right until the LSB is set.
// Optional NORM_EARLY_EXIT_EN: an operand that is zero or already normalized is
// accepted straight into DONE, so done follows start by a single cycle.
module norm_shift_seq #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned STAGES = $clog2(WIDTH)
) (
  input logic         clk,
  input logic         rst,
  norm_shift_if.slave bus
);

  localparam int unsigned JW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [STAGES:0] WidthCnt = (STAGES+1)'(WIDTH);

  typedef enum logic [1:0] {StIdle, StStep, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   w_q, w_d;
  logic               dir_q, dir_d;
  logic [STAGES:0]    acc_q, acc_d;
  logic               zop_q, zop_d;
  logic [JW-1:0]      j_q, j_d;
  logic [WIDTH-1:0]   c_q, c_d;
  logic [STAGES:0]    count_q, count_d;
  logic               zero_q, zero_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [STAGES:0]    step_amt;
  logic [STAGES:0]    keep_amt;
  logic [WIDTH-1:0]   w_step;
  logic [STAGES:0]    acc_step;
  logic               a_zero;

  // Next state: one search stage per STEP cycle, results written when entering DONE.
  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    dir_d    = dir_q;
    acc_d    = acc_q;
    zop_d    = zop_q;
    j_d      = j_q;
    c_d      = c_q;
    count_d  = count_q;
    zero_d   = zero_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    a_zero   = (bus.A == '0);

    // Stage width s = 1<<j; keep_amt moves the s tested bits to the far end of W.
    step_amt = (STAGES+1)'(1) << j_q;
    keep_amt = WidthCnt - step_amt;
    w_step   = w_q;
    acc_step = acc_q;
    if (dir_q) begin
      if ((w_q << keep_amt) == '0) begin
        w_step   = w_q >> step_amt;
        acc_step = acc_q + step_amt;
      end
    end else begin
      if ((w_q >> keep_amt) == '0) begin
        w_step   = w_q << step_amt;
        acc_step = acc_q + step_amt;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          w_d   = bus.A;
          dir_d = bus.dir;
          acc_d = '0;
          zop_d = a_zero;
          j_d   = JW'(STAGES - 1);
`ifdef NORM_EARLY_EXIT_EN
          if (a_zero || (bus.dir ? bus.A[0] : bus.A[WIDTH-1])) begin
            state_d = StDone;
            c_d     = bus.A;
            count_d = a_zero ? WidthCnt : '0;
            zero_d  = a_zero;
            done_d  = 1'b1;
          end else begin
            state_d = StStep;
            busy_d  = 1'b1;
          end
`else
          state_d = StStep;
          busy_d  = 1'b1;
`endif
        end
      end
      StStep: begin
        w_d   = w_step;
        acc_d = acc_step;
        if (j_q == '0) begin
          state_d = StDone;
          c_d     = w_step;
          // The search saturates at WIDTH-1 on a zero operand.
          count_d = zop_q ? WidthCnt : acc_step;
          zero_d  = zop_q;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          j_d = j_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      w_q     <= '0;
      dir_q   <= 1'b0;
      acc_q   <= '0;
      zop_q   <= 1'b0;
      j_q     <= '0;
      c_q     <= '0;
      count_q <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      dir_q   <= dir_d;
      acc_q   <= acc_d;
      zop_q   <= zop_d;
      j_q     <= j_d;
      c_q     <= c_d;
      count_q <= count_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.C     = c_q;
  assign bus.count = count_q;
  assign bus.zero  = zero_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_norm_shift_seq.sv
// Directed bench for norm_shift_seq at WIDTH 32 with a scoreboard of expected results.
module tb_norm_shift_seq;

  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] c;
    logic [5:0]   count;
    logic         zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  exp_t sb_q[$];
  logic [W-1:0] last_c;

  norm_shift_if #(.WIDTH(W)) bus ();

  norm_shift_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: scan for the first set bit instead of a binary search.
  function automatic exp_t model(input logic [W-1:0] a, input logic d);
    exp_t e;
    int   cnt;
    bit   found;
    cnt   = W;
    found = 1'b0;
    if (!d) begin
      for (int i = W - 1; i >= 0; i--)
        if (!found && a[i]) begin cnt = W - 1 - i; found = 1'b1; end
      e.c = a << cnt;
    end else begin
      for (int i = 0; i < W; i++)
        if (!found && a[i]) begin cnt = i; found = 1'b1; end
      e.c = a >> cnt;
    end
    e.count = 6'(cnt);
    e.zero  = (a == '0);
    return e;
  endfunction

  function automatic int exp_lat(input logic [W-1:0] a, input logic d);
`ifdef NORM_EARLY_EXIT_EN
    if (a == '0 || (d ? a[0] : a[W-1])) return 1;
`endif
    return 6;
  endfunction

  task automatic start_pulse(input logic [W-1:0] a, input logic d, input bit push);
    if (push) sb_q.push_back(model(a, d));
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.dir   = d;
  endtask

  // Counts edges until done (bounded), then checks latency, busy span and results.
  task automatic await_result(input string tag, input int lat, input int busy_n);
    int   cycles = 0;
    int   busy_seen = 0;
    bit   got = 1'b0;
    exp_t e;
    while (!got && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
      bus.start = 1'b0;
      if (bus.busy) busy_seen++;
      if (bus.done) got = 1'b1;
    end
    chk({tag, "_latency"}, 64'(cycles), 64'(lat));
    chk({tag, "_busy_cycles"}, 64'(busy_seen), 64'(busy_n));
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_C"}, 64'(bus.C), 64'(e.c));
      chk({tag, "_count"}, 64'(bus.count), 64'(e.count));
      chk({tag, "_zero"}, 64'(bus.zero), 64'(e.zero));
      last_c = e.c;
    end
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 64'(bus.done), 64'(0));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic d);
    int l;
    l = exp_lat(a, d);
    start_pulse(a, d, 1'b1);
    await_result(tag, l, (l == 1) ? 0 : 5);
  endtask

  initial begin
    int dn;
    bus.start = 1'b0;
    bus.dir   = 1'b0;
    bus.A     = '0;
    last_c    = '0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_C", 64'(bus.C), 64'(0));
    chk("rst_count", 64'(bus.count), 64'(0));
    chk("rst_zero", 64'(bus.zero), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    run_op("clz_one", 32'h0000_0001, 1'b0);
    run_op("ctz_bit16", 32'h0001_0000, 1'b1);
    run_op("clz_f0", 32'h00F0_0000, 1'b0);
    run_op("zero_left", 32'h0000_0000, 1'b0);
    run_op("zero_right", 32'h0000_0000, 1'b1);
    run_op("clz_msb", 32'h8000_0000, 1'b0);
    run_op("ctz_lsb", 32'h8000_0001, 1'b1);
    run_op("ctz_msb", 32'h8000_0000, 1'b1);

    // Results hold while idle.
    repeat (3) @(posedge clk);
    #1;
    chk("hold_C", 64'(bus.C), 64'(last_c));

    // A second start while busy is dropped.
    start_pulse(32'h0000_0100, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 32'hFFFF_FFFF;
    await_result("ignored_start", 4, 3);
    dn = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.done) dn++;
    end
    chk("ignored_no_second_done", 64'(dn), 64'(0));

    // Reset during the third STEP cycle discards the operation.
    start_pulse(32'h0000_1234, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'(0));
    chk("midrst_done", 64'(bus.done), 64'(0));
    chk("midrst_count", 64'(bus.count), 64'(0));
    chk("midrst_C", 64'(bus.C), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.done) dn++;
    end
    chk("midrst_no_done", 64'(dn), 64'(0));
    run_op("after_rst", 32'h0000_0300, 1'b1);

    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra;
      ra = $urandom() >> $urandom_range(31, 0);
      run_op("rand", ra, 1'(i & 1));
    end

    chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
